pes_bc_param: RTL



---
 rtl/pes_bc_param_if.sv | 25 ++
 rtl/pes_bc_param.sv | 109 ++++++++++
 2 files changed

// File: rtl/pes_bc_param_if.sv
// Control and status bundle for the parametrised up/down counter.
// The master drives the controls; the counter is the slave.
interface pes_bc_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             UpOrDown;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Count;
  logic             dir;
  logic             tc;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, UpOrDown, load, load_val,
    input  Count, dir, tc, at_max, at_min
  );

  modport slave (
    input  en, UpOrDown, load, load_val,
    output Count, dir, tc, at_max, at_min
  );
endinterface

// File: rtl/pes_bc_param.sv
// Parametrised up/down counter with wrap, saturate and bounce boundary modes,
// synchronous clamped load and a registered terminal-count pulse.
module pes_bc_param #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 15,
  parameter int unsigned MODE    = 0
) (
  input  logic          Clk,
  input  logic          reset_n,
  pes_bc_param_if.slave bus
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [XW-1:0] MAX_X = XW'(MAX_VAL);
  localparam bit IS_SAT = (MODE == 1);
  localparam bit IS_BNC = (MODE == 2);

  typedef enum logic {
    ST_DOWN = 1'b0,
    ST_UP   = 1'b1
  } dir_e;

  logic [WIDTH-1:0] r_count;
  dir_e             r_dir;
  logic             r_tc;

  logic [WIDTH-1:0] w_cnt_nxt;
  dir_e             w_dir_nxt;
  logic             w_tc_nxt;

  logic [XW-1:0]    w_cnt_x;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_ld_over;

  // Widened arithmetic so the compare and step never overflow at MAX_VAL
  assign w_cnt_x   = {1'b0, r_count};
  assign w_inc     = WIDTH'(w_cnt_x + XW'(1));
  assign w_dec     = WIDTH'(w_cnt_x - XW'(1));
  assign w_at_max  = (w_cnt_x == MAX_X);
  assign w_at_min  = (w_cnt_x == XW'(0));
  assign w_ld_over = ({1'b0, bus.load_val} > MAX_X);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_dir   <= ST_UP;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  // Next state: load > enabled step > hold; dir tracks UpOrDown except in bounce
  always_comb begin
    w_cnt_nxt = r_count;
    w_dir_nxt = IS_BNC ? r_dir : dir_e'(bus.UpOrDown);
    w_tc_nxt  = 1'b0;
    if (bus.load) begin
      w_cnt_nxt = w_ld_over ? WIDTH'(MAX_X) : bus.load_val;
      w_dir_nxt = dir_e'(bus.UpOrDown);
    end else if (bus.en) begin
      if (IS_BNC) begin
        if (r_dir == ST_UP) begin
          if (w_at_max) begin
            w_cnt_nxt = WIDTH'(MAX_X - XW'(1));
            w_dir_nxt = ST_DOWN;
            w_tc_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end else begin
          if (w_at_min) begin
            w_cnt_nxt = WIDTH'(1);
            w_dir_nxt = ST_UP;
            w_tc_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = w_dec;
          end
        end
      end else if (bus.UpOrDown) begin
        if (w_at_max) begin
          if (!IS_SAT) w_cnt_nxt = '0;
          w_tc_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_inc;
        end
      end else begin
        if (w_at_min) begin
          if (!IS_SAT) w_cnt_nxt = WIDTH'(MAX_X);
          w_tc_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_dec;
        end
      end
    end
  end

  assign bus.Count  = r_count;
  assign bus.dir    = r_dir;
  assign bus.tc     = r_tc;
  assign bus.at_max = w_at_max;
  assign bus.at_min = w_at_min;

endmodule
